// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode map, datapath select codes and the packed control vector that
// the output decoder hands to the top level.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_FETCH  = 5'd0,
        ST_DECODE = 5'd1,
        ST_RTYPE1 = 5'd2,
        ST_RTYPE2 = 5'd3,
        ST_SW     = 5'd4,
        ST_LW1    = 5'd5,
        ST_LW2    = 5'd6,
        ST_J      = 5'd7,
        ST_LI     = 5'd8,
        ST_MOV    = 5'd9,
        ST_BEQ1   = 5'd10,
        ST_BEQ2   = 5'd11,
        ST_JAL    = 5'd12,
        ST_PUSH   = 5'd13,
        ST_POP1   = 5'd14,
        ST_POP2   = 5'd15,
        ST_TRAP   = 5'd16
    } state_e;

    localparam logic [3:0] OP_LW    = 4'h0;
    localparam logic [3:0] OP_SW    = 4'h1;
    localparam logic [3:0] OP_J     = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_RTYPE = 4'h5;
    localparam logic [3:0] OP_LI    = 4'h7;
    localparam logic [3:0] OP_JAL   = 4'hC;
    localparam logic [3:0] OP_PUSH  = 4'hD;
    localparam logic [3:0] OP_POP   = 4'hE;
    localparam logic [3:0] OP_MOV   = 4'hF;

    localparam logic [1:0] PCSRC_JUMP   = 2'd0;
    localparam logic [1:0] PCSRC_INC    = 2'd1;
    localparam logic [1:0] PCSRC_BRANCH = 2'd2;
    localparam logic [1:0] PCSRC_TRAP   = 2'd3;

    localparam logic [2:0] RFWD_MDR    = 3'd0;
    localparam logic [2:0] RFWD_PC     = 3'd1;
    localparam logic [2:0] RFWD_REGA   = 3'd2;
    localparam logic [2:0] RFWD_ALUOUT = 3'd3;
    localparam logic [2:0] RFWD_IMM    = 3'd4;

    localparam logic [1:0] MADDR_ALUOUT = 2'd0;
    localparam logic [1:0] MADDR_PCSP   = 2'd1;
    localparam logic [1:0] MADDR_REGB   = 2'd3;

    localparam logic [1:0] RFWA_RD = 2'd0;
    localparam logic [1:0] RFWA_RA = 2'd1;
    localparam logic [1:0] RFWA_LI = 2'd2;

    typedef struct packed {
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic [1:0] maddr;
        logic       mdin;
        logic       mread;
        logic       mwrite;
        logic [1:0] rfwa;
        logic [2:0] rfwd;
        logic       rfread;
        logic       rdwrite;
        logic       spwrite;
        logic       awrite;
        logic       bwrite;
        logic       aluina;
        logic [1:0] aluinb;
        logic       aluoutwrite;
        logic       branch;
        logic       sprel;
        logic       pshpop;
        logic       trap;
    } ctrl_t;

    // States that talk to memory and therefore honour the ready handshake.
    function automatic logic is_mem_state(input state_e s);
        logic r;
        case (s)
            ST_FETCH, ST_SW, ST_LW1, ST_PUSH, ST_POP1: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/datapath bundle for the multicycle control unit.
// master: the controller (consumes Opcode/Funct/Comparison/MReady, drives
// all selects, strobes and CrtState). slave: the datapath side.
interface multicycle_control_fsm_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 4,
    parameter int STATE_W  = 5
);
    logic [OPCODE_W-1:0] Opcode;
    logic [ALUOP_W-1:0]  Funct;
    logic                Comparison;
    logic                MReady;
    logic [1:0]          PCSrc;
    logic                PCWrite;
    logic [1:0]          MAddr;
    logic                MDin;
    logic                MRead;
    logic                MWrite;
    logic [1:0]          RFWA;
    logic [2:0]          RFWD;
    logic                RFRead;
    logic                RDWrite;
    logic                SPWrite;
    logic                AWrite;
    logic                BWrite;
    logic                ALUInA;
    logic [1:0]          ALUInB;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                ALUOutWrite;
    logic                Branch;
    logic                SPRel;
    logic                PshPop;
    logic                Trap;
    logic [STATE_W-1:0]  CrtState;

    modport master (
        input  Opcode, Funct, Comparison, MReady,
        output PCSrc, PCWrite, MAddr, MDin, MRead, MWrite, RFWA, RFWD,
               RFRead, RDWrite, SPWrite, AWrite, BWrite, ALUInA, ALUInB,
               ALUOp, ALUOutWrite, Branch, SPRel, PshPop, Trap, CrtState
    );

    modport slave (
        output Opcode, Funct, Comparison, MReady,
        input  PCSrc, PCWrite, MAddr, MDin, MRead, MWrite, RFWA, RFWD,
               RFRead, RDWrite, SPWrite, AWrite, BWrite, ALUInA, ALUInB,
               ALUOp, ALUOutWrite, Branch, SPRel, PshPop, Trap, CrtState
    );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// ctrl_output_decode: combinational state -> control-vector decoder.
// Ports: state (current state), funct (R-type function), mready (memory
// ready), ctrl (selects and strobes), aluop (ALU operation).
// PC and SP updates in memory states are held back until mready so that
// each one lands on exactly one effective edge.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int CMP_ALUOP   = 5,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  state_e             state,
    input  logic [ALUOP_W-1:0] funct,
    input  logic               mready,
    output ctrl_t              ctrl,
    output logic [ALUOP_W-1:0] aluop
);
    logic go_s;

    assign go_s = ~MEM_WAIT_EN | mready;

    // Per-state control vector; anything not named stays 0.
    always_comb begin
        ctrl  = '0;
        aluop = '0;
        case (state)
            ST_FETCH: begin
                ctrl.pcwrite = go_s;
                ctrl.pcsrc   = PCSRC_INC;
                ctrl.maddr   = MADDR_PCSP;
                ctrl.mread   = 1'b1;
            end
            ST_DECODE: begin
                ctrl.rfread = 1'b1;
                ctrl.awrite = 1'b1;
                ctrl.bwrite = 1'b1;
            end
            ST_RTYPE1: begin
                ctrl.aluina      = 1'b1;
                ctrl.aluinb      = 2'd0;
                aluop            = funct;
                ctrl.aluoutwrite = 1'b1;
            end
            ST_RTYPE2: begin
                ctrl.rfwa    = RFWA_RD;
                ctrl.rfwd    = RFWD_ALUOUT;
                ctrl.rdwrite = 1'b1;
            end
            ST_SW: begin
                ctrl.mdin   = 1'b1;
                ctrl.maddr  = MADDR_REGB;
                ctrl.mwrite = 1'b1;
            end
            ST_LW1: begin
                ctrl.maddr = MADDR_ALUOUT;
                ctrl.mread = 1'b1;
            end
            ST_LW2, ST_POP2: begin
                ctrl.rfwd    = RFWD_MDR;
                ctrl.rfwa    = RFWA_RD;
                ctrl.rdwrite = 1'b1;
            end
            ST_J: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            ST_LI: begin
                ctrl.rfwa    = RFWA_LI;
                ctrl.rfwd    = RFWD_IMM;
                ctrl.rdwrite = 1'b1;
            end
            ST_MOV: begin
                ctrl.rfwd    = RFWD_REGA;
                ctrl.rfwa    = RFWA_RD;
                ctrl.rdwrite = 1'b1;
            end
            ST_BEQ1: begin
                aluop       = ALUOP_W'(CMP_ALUOP);
                ctrl.aluina = 1'b1;
                ctrl.aluinb = 2'd0;
            end
            ST_BEQ2: begin
                // Datapath ANDs Branch with Comparison to take the branch.
                ctrl.pcsrc  = PCSRC_BRANCH;
                ctrl.branch = 1'b1;
            end
            ST_JAL: begin
                ctrl.rfwd    = RFWD_PC;
                ctrl.rfwa    = RFWA_RA;
                ctrl.rdwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            ST_PUSH: begin
                ctrl.pshpop  = 1'b0;
                ctrl.maddr   = MADDR_PCSP;
                ctrl.spwrite = go_s;
                ctrl.mdin    = 1'b1;
                ctrl.mwrite  = 1'b1;
            end
            ST_POP1: begin
                ctrl.pshpop  = 1'b1;
                ctrl.maddr   = MADDR_PCSP;
                ctrl.spwrite = go_s;
                ctrl.mread   = 1'b1;
            end
            ST_TRAP: begin
                ctrl.pcsrc   = PCSRC_TRAP;
                ctrl.pcwrite = 1'b1;
                ctrl.trap    = 1'b1;
            end
            default: begin
                ctrl  = '0;
                aluop = '0;
            end
        endcase
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore FSM sequencing FETCH/DECODE/execute for the
// stack-capable datapath, with memory-ready stalls and an illegal-opcode
// trap. Ports: CLK, RST_N (async active-low), bus (master side of
// multicycle_control_fsm_if: opcode/funct/ready in, selects/strobes out).
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int ALUOP_W     = 4,
    parameter int STATE_W     = 5,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CMP_ALUOP   = 5
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    multicycle_control_fsm_if.master  bus
);
    // Opcode constants widened so upper opcode bits must be zero to match.
    localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_LI    = OPCODE_W'(OP_LI);
    localparam logic [OPCODE_W-1:0] OPC_JAL   = OPCODE_W'(OP_JAL);
    localparam logic [OPCODE_W-1:0] OPC_PUSH  = OPCODE_W'(OP_PUSH);
    localparam logic [OPCODE_W-1:0] OPC_POP   = OPCODE_W'(OP_POP);
    localparam logic [OPCODE_W-1:0] OPC_MOV   = OPCODE_W'(OP_MOV);

    state_e             state_r;
    state_e             state_next_s;
    ctrl_t              ctrl_s;
    logic [ALUOP_W-1:0] aluop_s;
    logic               hold_s;

    assign hold_s = MEM_WAIT_EN & ~bus.MReady & is_mem_state(state_r);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the opcode only steers the DECODE branch, so the
    // instruction is effectively latched into the state from then on.
    always_comb begin
        state_next_s = ST_FETCH;
        if (hold_s) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_FETCH:  state_next_s = ST_DECODE;
                ST_DECODE: begin
                    case (bus.Opcode)
                        OPC_LW:    state_next_s = ST_LW1;
                        OPC_SW:    state_next_s = ST_SW;
                        OPC_J:     state_next_s = ST_J;
                        OPC_BEQ:   state_next_s = ST_BEQ1;
                        OPC_RTYPE: state_next_s = ST_RTYPE1;
                        OPC_LI:    state_next_s = ST_LI;
                        OPC_JAL:   state_next_s = ST_JAL;
                        OPC_PUSH:  state_next_s = ST_PUSH;
                        OPC_POP:   state_next_s = ST_POP1;
                        OPC_MOV:   state_next_s = ST_MOV;
                        default:   state_next_s = ST_TRAP;
                    endcase
                end
                ST_RTYPE1: state_next_s = ST_RTYPE2;
                ST_LW1:    state_next_s = ST_LW2;
                ST_BEQ1:   state_next_s = ST_BEQ2;
                ST_POP1:   state_next_s = ST_POP2;
                default:   state_next_s = ST_FETCH;
            endcase
        end
    end

    ctrl_output_decode #(
        .ALUOP_W     (ALUOP_W),
        .CMP_ALUOP   (CMP_ALUOP),
        .MEM_WAIT_EN (MEM_WAIT_EN)
    ) u_decode (
        .state  (state_r),
        .funct  (bus.Funct),
        .mready (bus.MReady),
        .ctrl   (ctrl_s),
        .aluop  (aluop_s)
    );

    // Output drive; reset forces every select, strobe and CrtState to 0.
    always_comb begin
        if (RST_N) begin
            bus.PCSrc       = ctrl_s.pcsrc;
            bus.PCWrite     = ctrl_s.pcwrite;
            bus.MAddr       = ctrl_s.maddr;
            bus.MDin        = ctrl_s.mdin;
            bus.MRead       = ctrl_s.mread;
            bus.MWrite      = ctrl_s.mwrite;
            bus.RFWA        = ctrl_s.rfwa;
            bus.RFWD        = ctrl_s.rfwd;
            bus.RFRead      = ctrl_s.rfread;
            bus.RDWrite     = ctrl_s.rdwrite;
            bus.SPWrite     = ctrl_s.spwrite;
            bus.AWrite      = ctrl_s.awrite;
            bus.BWrite      = ctrl_s.bwrite;
            bus.ALUInA      = ctrl_s.aluina;
            bus.ALUInB      = ctrl_s.aluinb;
            bus.ALUOp       = aluop_s;
            bus.ALUOutWrite = ctrl_s.aluoutwrite;
            bus.Branch      = ctrl_s.branch;
            bus.SPRel       = ctrl_s.sprel;
            bus.PshPop      = ctrl_s.pshpop;
            bus.Trap        = ctrl_s.trap;
            bus.CrtState    = STATE_W'(state_r);
        end else begin
            bus.PCSrc       = 2'd0;
            bus.PCWrite     = 1'b0;
            bus.MAddr       = 2'd0;
            bus.MDin        = 1'b0;
            bus.MRead       = 1'b0;
            bus.MWrite      = 1'b0;
            bus.RFWA        = 2'd0;
            bus.RFWD        = 3'd0;
            bus.RFRead      = 1'b0;
            bus.RDWrite     = 1'b0;
            bus.SPWrite     = 1'b0;
            bus.AWrite      = 1'b0;
            bus.BWrite      = 1'b0;
            bus.ALUInA      = 1'b0;
            bus.ALUInB      = 2'd0;
            bus.ALUOp       = '0;
            bus.ALUOutWrite = 1'b0;
            bus.Branch      = 1'b0;
            bus.SPRel       = 1'b0;
            bus.PshPop      = 1'b0;
            bus.Trap        = 1'b0;
            bus.CrtState    = '0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed instruction
// sequences, a table-driven reference model compared every cycle, and
// hand-computed literal checks at key points.
module tb_multicycle_control_fsm;
    logic CLK = 1'b0;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;
    int   m_state = 0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Entry state of each legal opcode; everything else traps.
    function automatic int first_state(input int op);
        case (op)
            0:       return 5;
            1:       return 4;
            3:       return 7;
            4:       return 10;
            5:       return 2;
            7:       return 8;
            12:      return 12;
            13:      return 13;
            14:      return 14;
            15:      return 9;
            default: return 16;
        endcase
    endfunction

    function automatic bit mem_state(input int s);
        return (s == 0) || (s == 4) || (s == 5) || (s == 13) || (s == 14);
    endfunction

    function automatic int successor(input int s, input int op, input bit mr);
        if (mem_state(s) && !mr) return s;
        case (s)
            0:       return 1;
            1:       return first_state(op);
            2:       return 3;
            5:       return 6;
            10:      return 11;
            14:      return 15;
            default: return 0;
        endcase
    endfunction

    // Expected output vector straight from the per-state output table.
    function automatic logic [36:0] expected(input int s, input bit mr,
                                             input logic [3:0] fn, input bit rst_low);
        logic [1:0] pcsrc = 2'd0, maddr = 2'd0, rfwa = 2'd0, aluinb = 2'd0;
        logic [2:0] rfwd = 3'd0;
        logic [3:0] aluop = 4'd0;
        logic [4:0] crt;
        logic pcwrite = 1'b0, mdin = 1'b0, mread = 1'b0, mwrite = 1'b0;
        logic rfread = 1'b0, rdwrite = 1'b0, spwrite = 1'b0, awrite = 1'b0;
        logic bwrite = 1'b0, aluina = 1'b0, aluoutw = 1'b0, branch = 1'b0;
        logic sprel = 1'b0, pshpop = 1'b0, trap = 1'b0;
        if (rst_low) return 37'd0;
        crt = s[4:0];
        case (s)
            0:  begin pcwrite = mr; pcsrc = 2'd1; maddr = 2'd1; mread = 1'b1; end
            1:  begin rfread = 1'b1; awrite = 1'b1; bwrite = 1'b1; end
            2:  begin aluina = 1'b1; aluop = fn; aluoutw = 1'b1; end
            3:  begin rfwd = 3'd3; rdwrite = 1'b1; end
            4:  begin mdin = 1'b1; maddr = 2'd3; mwrite = 1'b1; end
            5:  begin mread = 1'b1; end
            6:  begin rdwrite = 1'b1; end
            7:  begin pcwrite = 1'b1; end
            8:  begin rfwa = 2'd2; rfwd = 3'd4; rdwrite = 1'b1; end
            9:  begin rfwd = 3'd2; rdwrite = 1'b1; end
            10: begin aluop = 4'd5; aluina = 1'b1; end
            11: begin pcsrc = 2'd2; branch = 1'b1; end
            12: begin rfwd = 3'd1; rfwa = 2'd1; rdwrite = 1'b1; pcwrite = 1'b1; end
            13: begin maddr = 2'd1; spwrite = mr; mdin = 1'b1; mwrite = 1'b1; end
            14: begin pshpop = 1'b1; maddr = 2'd1; spwrite = mr; mread = 1'b1; end
            15: begin rdwrite = 1'b1; end
            16: begin pcsrc = 2'd3; pcwrite = 1'b1; trap = 1'b1; end
            default: crt = 5'd0;
        endcase
        return {pcsrc, pcwrite, maddr, mdin, mread, mwrite, rfwa, rfwd, rfread,
                rdwrite, spwrite, awrite, bwrite, aluina, aluinb, aluop, aluoutw,
                branch, sprel, pshpop, trap, crt};
    endfunction

    logic [36:0] act_s;
    assign act_s = {bus.PCSrc, bus.PCWrite, bus.MAddr, bus.MDin, bus.MRead,
                    bus.MWrite, bus.RFWA, bus.RFWD, bus.RFRead, bus.RDWrite,
                    bus.SPWrite, bus.AWrite, bus.BWrite, bus.ALUInA, bus.ALUInB,
                    bus.ALUOp, bus.ALUOutWrite, bus.Branch, bus.SPRel, bus.PshPop,
                    bus.Trap, bus.CrtState};

    // Reference state tracker.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) m_state <= 0;
        else        m_state <= successor(m_state, int'(bus.Opcode), bus.MReady);
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge CLK) begin
        logic [36:0] exp_v;
        exp_v = expected(m_state, bus.MReady, bus.Funct, !RST_N);
        checks++;
        if (act_s !== exp_v) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t model_state=%0d actual=%h required=%h",
                     $time, m_state, act_s, exp_v);
        end
    end

    task automatic check_lit(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic step(input logic [3:0] op, input logic [3:0] fn, input bit mr);
        bus.Opcode = op;
        bus.Funct  = fn;
        bus.MReady = mr;
        @(posedge CLK);
        #2;
    endtask

    // One full instruction from FETCH; `waits` stall cycles in its memory states.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int waits);
        int w;
        w = waits;
        step(op, fn, 1'b1);
        step(op, fn, 1'b1);
        for (int i = 0; i < 12 && m_state != 0; i++) begin
            if (mem_state(m_state) && w > 0) begin
                step(~op, ~fn, 1'b0);
                w--;
            end else begin
                step(~op, ~fn, 1'b1);
            end
        end
        check_lit("instr_returns_to_fetch", m_state, 0);
    endtask

    initial begin
        RST_N          = 1'b0;
        bus.Opcode     = 4'h0;
        bus.Funct      = 4'h0;
        bus.MReady     = 1'b1;
        bus.Comparison = 1'b0;
        #12;
        check_lit("reset_crtstate", int'(bus.CrtState), 0);
        check_lit("reset_pcwrite", int'(bus.PCWrite), 0);
        check_lit("reset_mread", int'(bus.MRead), 0);
        RST_N = 1'b1;
        #1;
        check_lit("fetch_pcwrite", int'(bus.PCWrite), 1);
        check_lit("fetch_pcsrc", int'(bus.PCSrc), 1);
        check_lit("fetch_maddr", int'(bus.MAddr), 1);

        // R-type with Funct=3; opcode changes after DECODE must not matter.
        step(4'h5, 4'h3, 1'b1);
        check_lit("decode_rfread", int'(bus.RFRead), 1);
        check_lit("decode_awrite", int'(bus.AWrite), 1);
        step(4'h5, 4'h3, 1'b1);
        check_lit("rtype1_aluop", int'(bus.ALUOp), 3);
        check_lit("rtype1_aluina", int'(bus.ALUInA), 1);
        check_lit("rtype1_aluoutwrite", int'(bus.ALUOutWrite), 1);
        step(4'h9, 4'h3, 1'b1);
        check_lit("rtype2_rfwd", int'(bus.RFWD), 3);
        check_lit("rtype2_rdwrite", int'(bus.RDWrite), 1);
        step(4'h9, 4'h3, 1'b1);
        check_lit("rtype_back_to_fetch", int'(bus.CrtState), 0);

        // FETCH stall: PC write withheld while not ready.
        step(4'h0, 4'h0, 1'b0);
        check_lit("fetch_wait_state", int'(bus.CrtState), 0);
        check_lit("fetch_wait_pcwrite", int'(bus.PCWrite), 0);

        // LW with three stall cycles in LW1.
        step(4'h0, 4'h0, 1'b1);
        step(4'h0, 4'h0, 1'b0);
        check_lit("lw1_enter", int'(bus.CrtState), 5);
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 4'h0, 1'b0);
            check_lit("lw1_hold_state", int'(bus.CrtState), 5);
            check_lit("lw1_hold_mread", int'(bus.MRead), 1);
        end
        step(4'h0, 4'h0, 1'b1);
        check_lit("lw2_state", int'(bus.CrtState), 6);
        check_lit("lw2_rdwrite", int'(bus.RDWrite), 1);
        step(4'h0, 4'h0, 1'b1);

        // BEQ.
        step(4'h4, 4'h0, 1'b1);
        step(4'h4, 4'h0, 1'b1);
        check_lit("beq1_aluop", int'(bus.ALUOp), 5);
        step(4'h4, 4'h0, 1'b1);
        check_lit("beq2_pcsrc", int'(bus.PCSrc), 2);
        check_lit("beq2_branch", int'(bus.Branch), 1);
        check_lit("beq2_pcwrite", int'(bus.PCWrite), 0);
        step(4'h4, 4'h0, 1'b1);

        // Illegal opcode 2.
        step(4'h2, 4'h0, 1'b1);
        step(4'h2, 4'h0, 1'b1);
        check_lit("trap_pulse", int'(bus.Trap), 1);
        check_lit("trap_pcsrc", int'(bus.PCSrc), 3);
        check_lit("trap_state", int'(bus.CrtState), 16);
        step(4'h2, 4'h0, 1'b1);
        check_lit("trap_to_fetch", int'(bus.CrtState), 0);

        // Remaining instruction kinds, model-checked every cycle.
        run_instr(4'h1, 4'h0, 2);
        run_instr(4'h3, 4'h0, 0);
        run_instr(4'h6, 4'h0, 0);
        run_instr(4'h7, 4'h0, 0);
        run_instr(4'hC, 4'h0, 0);
        run_instr(4'hF, 4'h0, 0);
        run_instr(4'hD, 4'h0, 2);
        run_instr(4'hE, 4'h0, 1);
        run_instr(4'h5, 4'hA, 0);

        // PUSH then POP, with reset pulsed during POP1.
        step(4'hD, 4'h0, 1'b1);
        step(4'hD, 4'h0, 1'b1);
        check_lit("push_pshpop", int'(bus.PshPop), 0);
        check_lit("push_spwrite", int'(bus.SPWrite), 1);
        check_lit("push_state", int'(bus.CrtState), 13);
        step(4'hD, 4'h0, 1'b1);
        step(4'hE, 4'h0, 1'b1);
        step(4'hE, 4'h0, 1'b1);
        check_lit("pop1_pshpop", int'(bus.PshPop), 1);
        check_lit("pop1_spwrite", int'(bus.SPWrite), 1);
        check_lit("pop1_state", int'(bus.CrtState), 14);
        #1;
        RST_N = 1'b0;
        #1;
        check_lit("pop_reset_state", int'(bus.CrtState), 0);
        check_lit("pop_reset_spwrite", int'(bus.SPWrite), 0);
        check_lit("pop_reset_mread", int'(bus.MRead), 0);
        @(posedge CLK);
        #2;
        check_lit("pop_reset_hold_rdwrite", int'(bus.RDWrite), 0);
        RST_N = 1'b1;
        #1;
        check_lit("after_reset_state", int'(bus.CrtState), 0);
        run_instr(4'h7, 4'h0, 0);

        @(negedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
